// File: rtl/ifid_ctrl_pkg.sv
// Shared types and constants for the IF/ID hazard control unit.
package ifid_ctrl_pkg;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned MC_CNT_W = 4;

    // One bit per opcode: set when that opcode reads Fop2 (type A = opcode 0)
    localparam logic [15:0] FOP2_USE = 16'h0001;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        HALTED  = 2'd2
    } state_e;

endpackage

// File: rtl/ifid_sat_counter.sv
// Saturating up-counter used for the hazard unit performance counters.
module ifid_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Hold at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID stage sequencing: load-use stalls, multi-cycle op stalls, branch flush and HALT.
// Optional perf counters are built only when HAZ_PERF_CNT_EN is defined.
module ifid_hazard_ctrl
    import ifid_ctrl_pkg::*;
#(
    parameter logic [OPC_W-1:0] MC_OPCODE   = 4'hA,
    parameter int unsigned      MC_CYCLES   = 4,
    parameter logic [OPC_W-1:0] HALT_OPCODE = 4'hF,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ifid_valid,
    input  logic [OPC_W-1:0] ifid_opcode,
    input  logic [REG_W-1:0] ifid_fop1,
    input  logic [REG_W-1:0] ifid_fop2,
    input  logic             idex_valid,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mc_busy,
    output logic             halted,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    state_e              state_q, state_d;
    logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
    logic                load_use;
    logic                halt_hit;
    logic                mc_hit;

    assign load_use = idex_valid && idex_memread && (idex_rd != '0) && ifid_valid &&
                      ((idex_rd == ifid_fop1) ||
                       (FOP2_USE[ifid_opcode] && (idex_rd == ifid_fop2)));
    assign halt_hit = ifid_valid && (ifid_opcode == HALT_OPCODE);
    assign mc_hit   = ifid_valid && (ifid_opcode == MC_OPCODE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // Next state and same-cycle control outputs
    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        ifid_write  = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (halt_hit) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = HALTED;
                    end else if (mc_hit) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        mc_cnt_d    = MC_CNT_W'(MC_CYCLES - 1);
                        state_d     = MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    // A taken branch means the MC op in IF/ID was wrong-path
                    if (branch_taken) begin
                        ifid_write  = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        mc_cnt_d    = '0;
                        state_d     = RUN;
                    end else if (mc_cnt_q != '0) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        mc_cnt_d    = mc_cnt_q - MC_CNT_W'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                HALTED: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
                default: begin
                    state_d  = RUN;
                    mc_cnt_d = '0;
                end
            endcase
        end
    end

    assign mc_busy = (state_q == MC_BUSY);
    assign halted  = (state_q == HALTED);

`ifdef HAZ_PERF_CNT_EN
    ifid_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!ifid_write),
        .q     (perf_stall_cnt)
    );

    ifid_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ifid_flush),
        .q     (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Bench for ifid_hazard_ctrl: two instances (MC_CYCLES=4/CNT_W=4 and MC_CYCLES=1) against a rule-level model.
module tb_ifid_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ifid_valid = 1'b0;
    logic [3:0] ifid_opcode = '0;
    logic [3:0] ifid_fop1 = '0;
    logic [3:0] ifid_fop2 = '0;
    logic       idex_valid = 1'b0;
    logic       idex_memread = 1'b0;
    logic [3:0] idex_rd = '0;
    logic       branch_taken = 1'b0;

    logic        a_pw, a_iw, a_fl, a_bb, a_busy, a_halt;
    logic [3:0]  a_pstall, a_pflush;
    logic        b_pw, b_iw, b_fl, b_bb, b_busy, b_halt;
    logic [15:0] b_pstall, b_pflush;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifid_hazard_ctrl #(.MC_CYCLES(4), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .ifid_valid(ifid_valid), .ifid_opcode(ifid_opcode),
        .ifid_fop1(ifid_fop1), .ifid_fop2(ifid_fop2), .idex_valid(idex_valid),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .branch_taken(branch_taken),
        .pc_write(a_pw), .ifid_write(a_iw), .ifid_flush(a_fl), .idex_bubble(a_bb),
        .mc_busy(a_busy), .halted(a_halt), .perf_stall_cnt(a_pstall), .perf_flush_cnt(a_pflush)
    );

    ifid_hazard_ctrl #(.MC_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .ifid_valid(ifid_valid), .ifid_opcode(ifid_opcode),
        .ifid_fop1(ifid_fop1), .ifid_fop2(ifid_fop2), .idex_valid(idex_valid),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .branch_taken(branch_taken),
        .pc_write(b_pw), .ifid_write(b_iw), .ifid_flush(b_fl), .idex_bubble(b_bb),
        .mc_busy(b_busy), .halted(b_halt), .perf_stall_cnt(b_pstall), .perf_flush_cnt(b_pflush)
    );

    // Reference model: per instance, "halted", "busy with N stall cycles left" and cycle counts
    int unsigned MCC[2]  = '{4, 1};
    int unsigned CMAX[2] = '{15, 65535};
    bit m_halt[2];
    bit m_busy[2];
    int m_left[2];
    int m_stall[2];
    int m_flush[2];
    bit n_halt[2];
    bit n_busy[2];
    int n_left[2];
    bit e_pw[2], e_iw[2], e_fl[2], e_bb[2];
    bit armed = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_eval(input int k);
        bit lu;
        lu = idex_valid && idex_memread && (idex_rd != 0) && ifid_valid &&
             ((idex_rd == ifid_fop1) || ((ifid_opcode == 4'h0) && (idex_rd == ifid_fop2)));
        n_halt[k] = m_halt[k];
        n_busy[k] = m_busy[k];
        n_left[k] = m_left[k];
        e_pw[k] = 1; e_iw[k] = 1; e_fl[k] = 0; e_bb[k] = 0;
        if (!rst_n) begin
            e_pw[k] = 0; e_iw[k] = 0; e_fl[k] = 1; e_bb[k] = 1;
            n_halt[k] = 0; n_busy[k] = 0; n_left[k] = 0;
        end else if (m_halt[k]) begin
            e_pw[k] = 0; e_iw[k] = 0; e_bb[k] = 1;
        end else if (branch_taken) begin
            e_iw[k] = 0; e_fl[k] = 1; e_bb[k] = 1;
            n_busy[k] = 0; n_left[k] = 0;
        end else if (m_busy[k]) begin
            if (m_left[k] > 0) begin
                e_pw[k] = 0; e_iw[k] = 0; e_bb[k] = 1;
                n_left[k] = m_left[k] - 1;
            end else begin
                n_busy[k] = 0;
            end
        end else if (lu) begin
            e_pw[k] = 0; e_iw[k] = 0; e_bb[k] = 1;
        end else if (ifid_valid && ifid_opcode == 4'hF) begin
            e_pw[k] = 0; e_iw[k] = 0; e_bb[k] = 1;
            n_halt[k] = 1;
        end else if (ifid_valid && ifid_opcode == 4'hA) begin
            e_pw[k] = 0; e_iw[k] = 0; e_bb[k] = 1;
            n_busy[k] = 1;
            n_left[k] = int'(MCC[k]) - 1;
        end
    endtask

    task automatic model_commit(input int k);
        m_halt[k] = n_halt[k];
        m_busy[k] = n_busy[k];
        m_left[k] = n_left[k];
        if (!rst_n) begin
            m_stall[k] = 0;
            m_flush[k] = 0;
        end else begin
            if (!e_iw[k] && m_stall[k] < int'(CMAX[k])) m_stall[k]++;
            if (e_fl[k] && m_flush[k] < int'(CMAX[k])) m_flush[k]++;
        end
    endtask

    function automatic int perf_exp(input int v);
`ifdef HAZ_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check_all();
        chk("a.pc_write",    32'(a_pw), 32'(e_pw[0]));
        chk("a.ifid_write",  32'(a_iw), 32'(e_iw[0]));
        chk("a.ifid_flush",  32'(a_fl), 32'(e_fl[0]));
        chk("a.idex_bubble", 32'(a_bb), 32'(e_bb[0]));
        chk("b.pc_write",    32'(b_pw), 32'(e_pw[1]));
        chk("b.ifid_write",  32'(b_iw), 32'(e_iw[1]));
        chk("b.ifid_flush",  32'(b_fl), 32'(e_fl[1]));
        chk("b.idex_bubble", 32'(b_bb), 32'(e_bb[1]));
        if (armed) begin
            chk("a.mc_busy",    32'(a_busy),   32'(m_busy[0]));
            chk("a.halted",     32'(a_halt),   32'(m_halt[0]));
            chk("a.perf_stall", 32'(a_pstall), 32'(perf_exp(m_stall[0])));
            chk("a.perf_flush", 32'(a_pflush), 32'(perf_exp(m_flush[0])));
            chk("b.mc_busy",    32'(b_busy),   32'(m_busy[1]));
            chk("b.halted",     32'(b_halt),   32'(m_halt[1]));
            chk("b.perf_stall", 32'(b_pstall), 32'(perf_exp(m_stall[1])));
            chk("b.perf_flush", 32'(b_pflush), 32'(perf_exp(m_flush[1])));
        end
    endtask

    // One clock: drive on the falling edge, check settled outputs, advance model on the rising edge
    task automatic step(input bit r, input bit v, input logic [3:0] op, input logic [3:0] f1,
                        input logic [3:0] f2, input bit iv, input bit im, input logic [3:0] rd,
                        input bit br);
        @(negedge clk);
        rst_n = r; ifid_valid = v; ifid_opcode = op; ifid_fop1 = f1; ifid_fop2 = f2;
        idex_valid = iv; idex_memread = im; idex_rd = rd; branch_taken = br;
        #1;
        model_eval(0);
        model_eval(1);
        check_all();
        @(posedge clk);
        model_commit(0);
        model_commit(1);
        if (!r) armed = 1'b1;
    endtask

    initial begin
        // Reset
        step(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0);
        step(0, 1, 4'hA, 4'h1, 4'h2, 1, 1, 4'h1, 0);
        step(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0);

        // Load-use on Fop1, then the bubble has moved on
        step(1, 1, 4'h1, 4'h3, 4'h5, 1, 1, 4'h3, 0);
        step(1, 1, 4'h1, 4'h3, 4'h5, 0, 0, 4'h0, 0);
        // idex_rd = 0 never stalls; Fop2 only matters for opcode 0
        step(1, 1, 4'h1, 4'h0, 4'h0, 1, 1, 4'h0, 0);
        step(1, 1, 4'h2, 4'h4, 4'h6, 1, 1, 4'h6, 0);
        step(1, 1, 4'h0, 4'h4, 4'h6, 1, 1, 4'h6, 0);

        // Multi-cycle op held in IF/ID until release, then a plain instruction
        repeat (5) step(1, 1, 4'hA, 4'h1, 4'h2, 0, 0, 4'h0, 0);
        step(1, 1, 4'h1, 4'h1, 4'h2, 0, 0, 4'h0, 0);
        step(1, 1, 4'h1, 4'h1, 4'h2, 0, 0, 4'h0, 0);

        // Branch while MC_BUSY with two stall cycles left
        step(1, 1, 4'hA, 4'h1, 4'h2, 0, 0, 4'h0, 0);
        step(1, 1, 4'hA, 4'h1, 4'h2, 0, 0, 4'h0, 0);
        step(1, 1, 4'hA, 4'h1, 4'h2, 0, 0, 4'h0, 1);
        step(1, 1, 4'h1, 4'h1, 4'h2, 0, 0, 4'h0, 0);

        // Branch and load-use together: flush wins
        step(1, 1, 4'h1, 4'h3, 4'h5, 1, 1, 4'h3, 1);
        step(1, 1, 4'h1, 4'h7, 4'h5, 0, 0, 4'h0, 0);

        // HALT, branch ignored, long stall to saturate the narrow counter, then reset
        step(1, 1, 4'hF, 4'h0, 4'h0, 0, 0, 4'h0, 0);
        step(1, 1, 4'h1, 4'h0, 4'h0, 0, 0, 4'h0, 1);
        repeat (20) step(1, 1, 4'h1, 4'h0, 4'h0, 0, 0, 4'h0, 0);
        step(0, 1, 4'h1, 4'h0, 4'h0, 0, 0, 4'h0, 0);
        step(1, 1, 4'h1, 4'h0, 4'h0, 0, 0, 4'h0, 0);

        // Reset in the middle of MC_BUSY
        step(1, 1, 4'hA, 4'h1, 4'h2, 0, 0, 4'h0, 0);
        step(0, 1, 4'hA, 4'h1, 4'h2, 0, 0, 4'h0, 0);
        step(1, 1, 4'h1, 4'h1, 4'h2, 0, 0, 4'h0, 0);

        // Random traffic biased toward hazards on a few registers
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            int unsigned sel;
            sel = $urandom_range(0, 39);
            if (sel == 0)       op = 4'hF;
            else if (sel < 6)   op = 4'hA;
            else if (sel < 16)  op = 4'h0;
            else                op = 4'($urandom_range(1, 14));
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 7) != 0),
                 op,
                 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) != 0),
                 4'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
